// File: rtl/tx_arbiter_if.sv
// tx_arbiter_if: request/frame inputs and grant/transmitter outputs of the TX arbiter
interface tx_arbiter_if;
    logic [3:0]   req;
    logic [135:0] pkt0;
    logic [135:0] pkt1;
    logic [135:0] pkt2;
    logic [135:0] pkt3;
    logic [3:0]   ack;
    logic [1:0]   grant_id;
    logic         tx_start;
    logic [135:0] tx_packet;
    logic         busy;
    logic         tx_done;
    modport master (
        input  req, pkt0, pkt1, pkt2, pkt3,
        output ack, grant_id, tx_start, tx_packet, busy, tx_done
    );
    modport slave (
        output req, pkt0, pkt1, pkt2, pkt3,
        input  ack, grant_id, tx_start, tx_packet, busy, tx_done
    );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: 4-port round-robin frame arbiter with occupancy timing; TX_ARB_STRICT_PRIO_EN gives port 0 strict priority
module tx_arbiter #(
    parameter int IFG = 2
) (
    input logic          clk,
    input logic          rst,
    tx_arbiter_if.master bus
);
`ifdef TX_ARB_STRICT_PRIO_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;
    state_t       r_state, w_state;
    logic [7:0]   r_cnt, w_cnt;
    logic [1:0]   r_ptr, w_ptr;
    logic [3:0]   r_ack, w_ack;
    logic [1:0]   r_gid, w_gid;
    logic         r_start, w_start;
    logic [135:0] r_pkt, w_pkt;
    logic         r_busy, w_busy;
    logic         r_done, w_done;
    logic [3:0]   w_req;
    logic [1:0]   w_win;
    logic [135:0] w_sel;
    logic [7:0]   w_len;
    // Winner search starting at ptr; in strict mode a port-0 request masks everyone else
    always_comb begin
        w_req = (STRICT && bus.req[0]) ? 4'b0001 : bus.req;
        w_win = r_ptr;
        for (int i = 3; i >= 0; i--)
            if (w_req[r_ptr + 2'(i)]) w_win = r_ptr + 2'(i);
        w_sel = (w_win == 2'd0) ? bus.pkt0 : (w_win == 2'd1) ? bus.pkt1 : (w_win == 2'd2) ? bus.pkt2 : bus.pkt3;
        w_len = 8'd48 + {1'b0, w_sel[131:128], 3'b000};
    end
    // Next state and next value of every registered output
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ptr   = r_ptr;
        w_ack   = 4'b0000;
        w_gid   = r_gid;
        w_start = 1'b0;
        w_pkt   = r_pkt;
        w_busy  = r_busy;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.req != 4'b0000) begin
                    w_state = S_WAIT;
                    w_cnt   = w_len;
                    w_ptr   = (STRICT && w_win == 2'd0) ? r_ptr : w_win + 2'd1;
                    w_ack   = 4'b0001 << w_win;
                    w_gid   = w_win;
                    w_start = 1'b1;
                    w_pkt   = w_sel;
                    w_busy  = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt = r_cnt - 8'd1;
                if (r_cnt == 8'd1) begin
                    w_done  = 1'b1;
                    w_state = (IFG == 0) ? S_IDLE : S_GAP;
                    w_cnt   = 8'(IFG);
                    w_busy  = (IFG != 0);
                end
            end
            S_GAP: begin
                w_cnt = r_cnt - 8'd1;
                if (r_cnt <= 8'd1) begin
                    w_state = S_IDLE;
                    w_cnt   = 8'd0;
                    w_busy  = 1'b0;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end
    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_ptr   <= 2'd0;
            r_ack   <= 4'b0000;
            r_gid   <= 2'd0;
            r_start <= 1'b0;
            r_pkt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ptr   <= w_ptr;
            r_ack   <= w_ack;
            r_gid   <= w_gid;
            r_start <= w_start;
            r_pkt   <= w_pkt;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end
    assign bus.ack       = r_ack;
    assign bus.grant_id  = r_gid;
    assign bus.tx_start  = r_start;
    assign bus.tx_packet = r_pkt;
    assign bus.busy      = r_busy;
    assign bus.tx_done   = r_done;
endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter IFG, default 2, giving the idle cycles inserted after each frame before the next grant (range 0..255).
REQ-002 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-004 SHALL have port req  input  4  per-port send request, held until that port's ack.
REQ-005 SHALL have ports pkt0..pkt3  input  136 each  per-port frame: [135:128] header, [131:128] length field, [127:0] payload.
REQ-006 SHALL have port ack  output  4  one-hot, one-cycle grant pulse.
REQ-007 SHALL have port grant_id  output  2  index of the last granted port.
REQ-008 SHALL have port tx_start  output  1  one-cycle start pulse to the serial transmitter.
REQ-009 SHALL have port tx_packet  output  136  latched frame to the transmitter.
REQ-010 SHALL have port busy  output  1  high while a frame or inter-frame gap is in progress.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse when the transmitter's occupancy window ends.

Function
REQ-012 SHALL implement the states S_IDLE, S_WAIT and S_GAP; every output SHALL be registered.
REQ-013 In S_IDLE with req!=0, one edge SHALL: pick the winner; load tx_packet from its pkt; set tx_start=1, ack[w]=1, grant_id=w, busy=1; load cnt=N; go to S_WAIT.
REQ-014 SHALL compute N = 48 + 8*L, where L = winner pkt[131:128]: 16 preamble + 8 SFD + 8 header + 8*(L+1) data + 8 CRC cycles; N ranges 48..168 and cnt is 8 bits wide.
REQ-015 tx_start and ack SHALL be high for exactly one cycle and SHALL clear on the next edge.
REQ-016 S_WAIT SHALL decrement cnt on every edge.
REQ-017 When cnt==1, the edge SHALL set tx_done=1 and move to S_GAP (IFG>0) or S_IDLE (IFG=0; busy=0 on the same edge).
REQ-018 S_GAP SHALL count IFG cycles, then move to S_IDLE and set busy=0.
REQ-019 The tx_start spacing SHALL be N+1+IFG cycles, rising edge to rising edge. With IFG=0, the transmitter samples the next start on the first edge it is back in idle.
REQ-020 Arbitration SHALL be 4-way round-robin: the search starts at ptr and wraps 3->0; after a grant, ptr = w+1 mod 4.
REQ-021 req SHALL be ignored in S_WAIT and S_GAP; a request raised then SHALL be served in the next S_IDLE.
REQ-022 tx_packet SHALL hold its latched value until the next grant, regardless of pkt changes.
REQ-023 A requester dropping req before ack SHALL lose its slot without any error; no partial grant is made.
REQ-024 In S_IDLE with req==0, all outputs except tx_packet and grant_id SHALL be 0.

Reset
REQ-025 With rst=1 on an edge: state=S_IDLE, ptr=0, cnt=0, tx_start=0, ack=0, grant_id=0, tx_packet=0, busy=0, tx_done=0.
REQ-026 Reset SHALL take priority over every other event, including an in-progress S_WAIT/S_GAP or a simultaneous req.
REQ-027 The first grant after reset SHALL go to the lowest-numbered requesting port.
REQ-028 The system SHALL reset the transmitter together with this block; mid-frame reset of one alone is unsupported.

Configuration
REQ-029 With macro TX_ARB_STRICT_PRIO_EN defined, port 0 SHALL win whenever req[0]=1 in S_IDLE. Ports 1..3 SHALL round-robin among themselves, and port 0 grants SHALL NOT move ptr.
REQ-030 Without TX_ARB_STRICT_PRIO_EN, pure 4-way round-robin per REQ-020 SHALL apply.

Verification
REQ-031 Scenario: IFG=0, req[2]=1 alone, L=0 -> ack=0100 and tx_start in the same cycle; tx_done 48 cycles after tx_start rises; busy low the following cycle.
REQ-032 Scenario: IFG=2, req=1111 held, all L=15 -> grant order 0,1,2,3,0; tx_start spacing 171 cycles; exactly one tx_start per frame.
REQ-033 Scenario: rst pulsed on cycle 20 of S_WAIT -> next cycle all outputs 0 and busy=0; with req=1010 after release, port 1 granted first.
REQ-034 Scenario: req[0] and req[3] held -> without the macro grants alternate 0,3,0,3; with TX_ARB_STRICT_PRIO_EN, grants are 0,0,0.
REQ-035 Scenario: pkt1 changed to all-ones the cycle after ack[1] -> tx_packet keeps the originally latched value until the next grant.
REQ-036 Scenario: req[3] rises during S_GAP -> no ack until S_IDLE, then ack=1000 on the first S_IDLE edge.
